// File: rtl/icache_dm_pkg.sv
// rtl/icache_dm_pkg.sv - shared types and constants for the direct-mapped instruction cache
package icache_dm_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2
  } icache_state_t;

endpackage

// File: rtl/icache_dm_refill_fsm.sv
// rtl/icache_dm_refill_fsm.sv - line refill sequencer: one-cycle memory request, then LINE_WORDS beats
module icache_refill_fsm
  import icache_dm_pkg::*;
#(
  parameter int XLEN       = icache_dm_pkg::XLEN,
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          miss,
  input  logic [XLEN-1:0]               line_adr,
  input  logic                          flush,
  input  logic                          mem_rvalid,
  output icache_state_t                 state,
  output logic                          mem_req,
  output logic [XLEN-1:0]               mem_adr,
  output logic                          fill_we,
  output logic [$clog2(LINE_WORDS)-1:0] fill_word,
  output logic                          fill_last,
  output logic                          fill_valid
);

  localparam int WB = $clog2(LINE_WORDS);
  localparam logic [WB-1:0] LAST_BEAT = WB'(LINE_WORDS - 1);

  icache_state_t   state_q, state_d;
  logic [WB-1:0]   beat_cnt;
  logic            flush_pend;
  logic [XLEN-1:0] cap_adr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      beat_cnt   <= '0;
      flush_pend <= 1'b0;
      cap_adr    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && miss) cap_adr <= line_adr;
      if (state_q == REQ) beat_cnt <= '0;
      else if (fill_we)   beat_cnt <= beat_cnt + 1'b1;
      // a flush seen while the refill is in flight must keep the incoming line invalid
      if (fill_last)                       flush_pend <= 1'b0;
      else if (state_q != IDLE && flush)   flush_pend <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    fill_we   = 1'b0;
    fill_last = 1'b0;
    case (state_q)
      IDLE: if (miss) state_d = REQ;
      REQ: begin
        mem_req = 1'b1;
        state_d = FILL;
      end
      FILL: if (mem_rvalid) begin
        fill_we = 1'b1;
        if (beat_cnt == LAST_BEAT) begin
          fill_last = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state      = state_q;
  assign mem_adr    = cap_adr;
  assign fill_word  = beat_cnt;
  assign fill_valid = ~flush_pend & ~flush;

endmodule

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped icache, zero-latency hit; ICACHE_PERF_CNT_EN adds hit/miss counters
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int XLEN       = icache_dm_pkg::XLEN,
  parameter int NB_LINES   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            icache_req_i,
  input  logic [XLEN-1:0] icache_adr_i,
  input  logic            icache_flush_i,
  output logic [31:0]     icache_instr_o,
  output logic            icache_instr_v_o,
  output logic            icache_stall_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_adr_o,
  input  logic [31:0]     mem_rdata_i,
  input  logic            mem_rvalid_i
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]     hit_cnt_o,
  output logic [31:0]     miss_cnt_o
`endif
);

  localparam int WB   = $clog2(LINE_WORDS);
  localparam int OFFS = 2 + WB;
  localparam int IW   = $clog2(NB_LINES);
  localparam int TW   = XLEN - OFFS - IW;

  logic [NB_LINES-1:0] valid;
  logic [TW-1:0]       tags [NB_LINES];
  logic [31:0]         data [NB_LINES][LINE_WORDS];

  logic [WB-1:0]   word;
  logic [IW-1:0]   index;
  logic [TW-1:0]   tag;
  logic [IW-1:0]   cap_index;
  logic [TW-1:0]   cap_tag;
  logic [XLEN-1:0] line_adr;
  logic            unused_adr_bits;

  icache_state_t  state;
  logic           idle, hit, miss;
  logic           fill_we, fill_last, fill_valid;
  logic [WB-1:0]  fill_word;

  assign word            = icache_adr_i[OFFS-1:2];
  assign index           = icache_adr_i[OFFS+IW-1:OFFS];
  assign tag             = icache_adr_i[XLEN-1:OFFS+IW];
  assign line_adr        = {icache_adr_i[XLEN-1:OFFS], {OFFS{1'b0}}};
  assign unused_adr_bits = ^icache_adr_i[1:0];
  assign cap_index       = mem_adr_o[OFFS+IW-1:OFFS];
  assign cap_tag         = mem_adr_o[XLEN-1:OFFS+IW];

  assign idle = (state == IDLE);
  assign hit  = icache_req_i & idle & valid[index] & (tags[index] == tag) & ~icache_flush_i;
  assign miss = icache_req_i & idle & ~icache_flush_i & ~hit;

  assign icache_instr_v_o = hit;
  assign icache_instr_o   = hit ? data[index][word] : NOP;
  assign icache_stall_o   = (icache_req_i & ~hit & idle) | ~idle;

  icache_refill_fsm #(
    .XLEN       (XLEN),
    .LINE_WORDS (LINE_WORDS)
  ) u_refill (
    .clk        (clk),
    .reset_n    (reset_n),
    .miss       (miss),
    .line_adr   (line_adr),
    .flush      (icache_flush_i),
    .mem_rvalid (mem_rvalid_i),
    .state      (state),
    .mem_req    (mem_req_o),
    .mem_adr    (mem_adr_o),
    .fill_we    (fill_we),
    .fill_word  (fill_word),
    .fill_last  (fill_last),
    .fill_valid (fill_valid)
  );

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data[cap_index][fill_word] <= mem_rdata_i;
      if (fill_last) tags[cap_index] <= cap_tag;
    end
  end

  // the refilled line's valid write follows the flush clear, so fill_valid decides it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
    end else begin
      if (icache_flush_i) valid <= '0;
      if (fill_last)      valid[cap_index] <= fill_valid;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit)  hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (miss) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// tb/tb_icache_dm.sv - self-checking bench for icache_dm with a scoreboard of expected fetch results
module tb_icache_dm;
  import icache_dm_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        icache_req_i = 1'b0;
  logic [31:0] icache_adr_i = '0;
  logic        icache_flush_i = 1'b0;
  logic [31:0] icache_instr_o;
  logic        icache_instr_v_o;
  logic        icache_stall_o;
  logic        mem_req_o;
  logic [31:0] mem_adr_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_rvalid_i = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int req_seen = 0;
  logic [31:0] exp_q[$];

  icache_dm #(.XLEN(32), .NB_LINES(16), .LINE_WORDS(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .icache_req_i     (icache_req_i),
    .icache_adr_i     (icache_adr_i),
    .icache_flush_i   (icache_flush_i),
    .icache_instr_o   (icache_instr_o),
    .icache_instr_v_o (icache_instr_v_o),
    .icache_stall_o   (icache_stall_o),
    .mem_req_o        (mem_req_o),
    .mem_adr_o        (mem_adr_o),
    .mem_rdata_i      (mem_rdata_i),
    .mem_rvalid_i     (mem_rvalid_i)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt_o        (hit_cnt_o),
    .miss_cnt_o       (miss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mem_req_o === 1'b1) req_seen++;

  function automatic logic [31:0] mem_model(input logic [31:0] line, input int w);
    if (line == 32'h80) return 32'h11 * (w + 1);
    return {line[23:0], 8'(w)} ^ 32'h5A00_0000;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Full miss sequence on adr; with flush_mid the first refill is flushed and must be redone.
  task automatic miss_refill(input logic [31:0] adr, input int max_gap, input bit flush_mid);
    logic [31:0] line;
    logic [31:0] exp;
    int req_before;
    int gap;
    line = adr & ~32'hF;
    req_before = req_seen;
    icache_req_i = 1'b1;
    icache_adr_i = adr;
    for (int pass = 0; pass < (flush_mid ? 2 : 1); pass++) begin
      @(negedge clk);
      checks++;
      if (icache_stall_o !== 1'b1 || icache_instr_v_o !== 1'b0 || icache_instr_o !== NOP) begin
        errors++;
        $display("FAIL miss_lookup adr=%h stall=%b v=%b instr=%h want stall=1 v=0 instr=%h",
                 adr, icache_stall_o, icache_instr_v_o, icache_instr_o, NOP);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (mem_req_o !== 1'b1 || mem_adr_o !== line || icache_stall_o !== 1'b1) begin
        errors++;
        $display("FAIL refill_req adr=%h mem_req=%b mem_adr=%h stall=%b want 1 %h 1",
                 adr, mem_req_o, mem_adr_o, icache_stall_o, line);
      end
      next_cycle();
      for (int b = 0; b < 4; b++) begin
        gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        if (flush_mid && pass == 0 && b == 2) begin
          icache_flush_i = 1'b1;
          next_cycle();
          icache_flush_i = 1'b0;
        end
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          checks++;
          if (icache_stall_o !== 1'b1 || mem_req_o !== 1'b0 || icache_instr_v_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_gap adr=%h beat=%0d stall=%b mem_req=%b v=%b want 1 0 0",
                     adr, b, icache_stall_o, mem_req_o, icache_instr_v_o);
          end
          next_cycle();
        end
        mem_rdata_i  = mem_model(line, b);
        mem_rvalid_i = 1'b1;
        next_cycle();
        mem_rvalid_i = 1'b0;
      end
    end
    exp_q.push_back(mem_model(line, int'(adr[3:2])));
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (icache_stall_o !== 1'b0 || icache_instr_v_o !== 1'b1 || icache_instr_o !== exp) begin
      errors++;
      $display("FAIL refill_hit adr=%h stall=%b v=%b instr=%h want stall=0 v=1 instr=%h",
               adr, icache_stall_o, icache_instr_v_o, icache_instr_o, exp);
    end
    checks++;
    if (req_seen - req_before !== (flush_mid ? 2 : 1)) begin
      errors++;
      $display("FAIL mem_req_count adr=%h got %0d want %0d", adr, req_seen - req_before,
               flush_mid ? 2 : 1);
    end
    next_cycle();
    icache_req_i = 1'b0;
  endtask

  task automatic expect_hit(input logic [31:0] adr);
    logic [31:0] exp;
    icache_req_i = 1'b1;
    icache_adr_i = adr;
    exp_q.push_back(mem_model(adr & ~32'hF, int'(adr[3:2])));
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (icache_instr_v_o !== 1'b1 || icache_stall_o !== 1'b0 || mem_req_o !== 1'b0 ||
        icache_instr_o !== exp) begin
      errors++;
      $display("FAIL warm_hit adr=%h v=%b stall=%b mem_req=%b instr=%h want 1 0 0 %h",
               adr, icache_instr_v_o, icache_stall_o, mem_req_o, icache_instr_o, exp);
    end
    next_cycle();
    icache_req_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks++;
    if (mem_req_o !== 1'b0 || mem_adr_o !== 32'h0 || icache_instr_v_o !== 1'b0 ||
        icache_stall_o !== 1'b0 || icache_instr_o !== NOP) begin
      errors++;
      $display("FAIL reset_state mem_req=%b mem_adr=%h v=%b stall=%b instr=%h want 0 0 0 0 %h",
               mem_req_o, mem_adr_o, icache_instr_v_o, icache_stall_o, icache_instr_o, NOP);
    end
    repeat (2) next_cycle();
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_cold_miss();
    miss_refill(32'h80, 0, 1'b0);
  endtask

  task automatic test_warm_hit();
    expect_hit(32'h8C);
  endtask

  task automatic test_conflict();
    miss_refill(32'h180, 0, 1'b0);
    expect_hit(32'h188);
    miss_refill(32'h80, 0, 1'b0);
  endtask

  task automatic test_flush();
    icache_req_i   = 1'b1;
    icache_adr_i   = 32'h80;
    icache_flush_i = 1'b1;
    @(negedge clk);
    checks++;
    if (icache_instr_v_o !== 1'b0 || icache_instr_o !== NOP || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_hit v=%b instr=%h mem_req=%b want 0 %h 0",
               icache_instr_v_o, icache_instr_o, mem_req_o, NOP);
    end
    next_cycle();
    icache_flush_i = 1'b0;
    miss_refill(32'h80, 0, 1'b0);
    miss_refill(32'h2C4, 1, 1'b1);
    expect_hit(32'h2C0);
  endtask

  task automatic test_gapped_beats();
    miss_refill(32'h3C4, 3, 1'b0);
    for (int w = 0; w < 4; w++) expect_hit(32'h3C0 + 32'(w * 4));
  endtask

  task automatic test_reset_mid_fill();
    icache_req_i = 1'b1;
    icache_adr_i = 32'h500;
    next_cycle();
    next_cycle();
    for (int b = 0; b < 2; b++) begin
      mem_rdata_i  = mem_model(32'h500, b);
      mem_rvalid_i = 1'b1;
      next_cycle();
    end
    mem_rvalid_i = 1'b0;
    icache_req_i = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || mem_adr_o !== 32'h0 || icache_instr_v_o !== 1'b0 ||
        icache_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fill mem_req=%b mem_adr=%h v=%b stall=%b want 0 0 0 0",
               mem_req_o, mem_adr_o, icache_instr_v_o, icache_stall_o);
    end
    mem_rdata_i  = 32'hDEAD_BEEF;
    mem_rvalid_i = 1'b1;
    next_cycle();
    next_cycle();
    reset_n = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (icache_stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL stray_beats stall=%b mem_req=%b want 0 0", icache_stall_o, mem_req_o);
    end
    next_cycle();
    mem_rvalid_i = 1'b0;
    miss_refill(32'h80, 0, 1'b0);
    miss_refill(32'h504, 2, 1'b0);
  endtask

`ifdef ICACHE_PERF_CNT_EN
  task automatic test_perf_counters();
    checks++;
    if (hit_cnt_o !== 32'd2 || miss_cnt_o !== 32'd1) begin
      errors++;
      $display("FAIL perf_cnt hit=%0d miss=%0d want 2 1", hit_cnt_o, miss_cnt_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_warm_hit();
`ifdef ICACHE_PERF_CNT_EN
    test_perf_counters();
`endif
    test_conflict();
    test_flush();
    test_gapped_beats();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
